// File: rtl/merge_sync_bridge.sv
// merge_sync_bridge: async drive/free channel to clocked valid/ready FIFO stream; MERGE_SYNC_BRIDGE_STAT_EN adds stall/word counters
module merge_sync_bridge #(
  parameter int DATA_WIDTH        = 32,
  parameter int FIFO_DEPTH        = 4,
  parameter int SYNC_STAGES       = 2,
  parameter int FREE_PULSE_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_drive,
  input  logic [DATA_WIDTH-1:0]         i_data,
  output logic                          o_free,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [DATA_WIDTH-1:0]         o_data,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
`ifdef MERGE_SYNC_BRIDGE_STAT_EN
  ,
  output logic [15:0]                   o_stall_cnt,
  output logic [15:0]                   o_word_cnt
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(FREE_PULSE_CYCLES + 1);
  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_FREE, S_WAIT_LOW} state_t;
  state_t                  r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0]  r_sync;
  logic                    r_drv_d;
  logic                    r_free;
  logic [PW-1:0]           r_pcnt;
  logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]           r_wptr, r_rptr;
  logic [CW-1:0]           r_count;
  logic                    w_drv_s, w_rise, w_full, w_pop, w_push;
  assign w_drv_s = r_sync[SYNC_STAGES-1];
  assign w_rise  = w_drv_s & ~r_drv_d;
  assign w_full  = r_count == CW'(FIFO_DEPTH);
  assign w_pop   = o_valid & i_ready;
  assign o_valid = r_count != '0;
  assign o_data  = o_valid ? r_mem[r_rptr] : '0;
  assign o_count = r_count;
  assign o_free  = r_free;
  // drive synchronizer plus one delay flop for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '0;
      r_drv_d <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_drive};
      r_drv_d <= w_drv_s;
    end
  end
  // capture waits for room (or a same-cycle pop) so a full FIFO stalls the merge stage instead of dropping data
  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE:     w_state_nxt = w_rise ? S_CAPTURE : S_IDLE;
      S_CAPTURE: begin
        w_push      = ~w_full | w_pop;
        w_state_nxt = w_push ? S_FREE : S_CAPTURE;
      end
      S_FREE:     w_state_nxt = (r_pcnt <= PW'(1)) ? S_WAIT_LOW : S_FREE;
      S_WAIT_LOW: w_state_nxt = w_drv_s ? S_WAIT_LOW : S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end
  // state, registered free pulse and its length counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_free  <= 1'b0;
      r_pcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_free  <= w_state_nxt == S_FREE;
      r_pcnt  <= w_push ? PW'(FREE_PULSE_CYCLES) : (r_state == S_FREE) ? r_pcnt - PW'(1) : r_pcnt;
    end
  end
  // circular buffer storage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < FIFO_DEPTH; k++) r_mem[k] <= '0;
    end else if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end
  // pointers wrap modulo depth; occupancy nets push against pop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= w_push ? r_wptr + AW'(1) : r_wptr;
      r_rptr  <= w_pop ? r_rptr + AW'(1) : r_rptr;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
`ifdef MERGE_SYNC_BRIDGE_STAT_EN
  logic [15:0] r_stall_cnt, r_word_cnt;
  assign o_stall_cnt = r_stall_cnt;
  assign o_word_cnt  = r_word_cnt;
  // saturating full-FIFO stall counter and wrapping accepted-word counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_word_cnt  <= '0;
    end else begin
      r_stall_cnt <= (r_state == S_CAPTURE && w_full && !w_pop && r_stall_cnt != 16'hFFFF) ? r_stall_cnt + 16'd1 : r_stall_cnt;
      r_word_cnt  <= r_word_cnt + 16'(w_push);
    end
  end
`endif
endmodule

// File: tb/tb_merge_sync_bridge.sv
// tb_merge_sync_bridge: directed/randomized bench for merge_sync_bridge with an in-order word queue model
module tb_merge_sync_bridge;
  localparam int DW = 32, DEPTH = 4, SS = 2, FP = 2;
  logic clk = 1'b0, rst, i_drive, i_ready, o_free, o_valid;
  logic [DW-1:0] i_data, o_data;
  logic [2:0] o_count;
`ifdef MERGE_SYNC_BRIDGE_STAT_EN
  logic [15:0] o_stall_cnt, o_word_cnt;
`endif
  int n_tests = 0, n_fail = 0;
  logic [DW-1:0] q[$];
  bit toggle_rdy = 1'b0;
  always #5 clk = ~clk;
  merge_sync_bridge #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SS), .FREE_PULSE_CYCLES(FP)) dut (
    .clk(clk), .rst(rst), .i_drive(i_drive), .i_data(i_data), .o_free(o_free),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_count(o_count)
`ifdef MERGE_SYNC_BRIDGE_STAT_EN
    , .o_stall_cnt(o_stall_cnt), .o_word_cnt(o_word_cnt)
`endif
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    if (o_valid === 1'b1 && i_ready) begin
      chk("pop_has_expected_word", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        chk("pop_order", 64'(o_data), 64'(q[0]));
        void'(q.pop_front());
      end
    end
    @(posedge clk);
    #1;
    if (toggle_rdy) i_ready = ~i_ready;
  endtask
  task automatic xfer(input logic [DW-1:0] d, input int hold);
    int seen, n, extra;
    seen = 0; n = 0; extra = 0;
    i_data = d; i_drive = 1'b1; q.push_back(d);
    while (n < 40 && !(seen > 0 && !o_free)) begin
      cyc(); n++;
      if (o_free) seen++;
    end
    chk("free_width", 64'(seen), 64'(FP));
    repeat (hold) begin
      cyc();
      if (o_free) extra++;
    end
    if (hold > 0) chk("held_drive_single_free", 64'(extra), 64'd0);
    i_drive = 1'b0;
    repeat (SS + 3) cyc();
  endtask
  task automatic drain();
    int n;
    n = 0;
    i_ready = 1'b1;
    while (q.size() != 0 && n < 60) begin cyc(); n++; end
    cyc();
    chk("drain_model_empty", 64'(q.size()), 64'd0);
    chk("drain_valid_low", 64'(o_valid), 64'd0);
    chk("drain_count_zero", 64'(o_count), 64'd0);
    i_ready = 1'b0;
  endtask
  initial begin
    int lat, fc, n;
    logic [15:0] w0, s0;
    rst = 1'b1; i_drive = 1'b0; i_ready = 1'b0; i_data = '0;
    repeat (3) cyc();
    chk("rst_free", 64'(o_free), 64'd0);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_count", 64'(o_count), 64'd0);
    chk("rst_data", 64'(o_data), 64'd0);
`ifdef MERGE_SYNC_BRIDGE_STAT_EN
    chk("rst_stall_cnt", 64'(o_stall_cnt), 64'd0);
    chk("rst_word_cnt", 64'(o_word_cnt), 64'd0);
`endif
    rst = 1'b0;
    repeat (2) cyc();
    i_ready = 1'b1; i_data = 32'hA5A5_0001; i_drive = 1'b1; q.push_back(32'hA5A5_0001);
    lat = 0;
    while (o_valid !== 1'b1 && lat < 20) begin cyc(); lat++; end
    chk("single_latency_in_window", 64'(lat >= SS + 1 && lat <= SS + 3), 64'd1);
    chk("single_data", 64'(o_data), 64'hA5A5_0001);
    fc = 0;
    while (o_free && fc < 20) begin fc++; cyc(); end
    chk("single_free_width", 64'(fc), 64'(FP));
    chk("single_count_after_pop", 64'(o_count), 64'd0);
    i_drive = 1'b0; i_ready = 1'b0;
    repeat (SS + 3) cyc();
`ifdef MERGE_SYNC_BRIDGE_STAT_EN
    w0 = o_word_cnt; s0 = o_stall_cnt;
`else
    w0 = '0; s0 = '0;
`endif
    for (int i = 1; i <= 4; i++) xfer(DW'(i), 0);
    chk("fill_count_4", 64'(o_count), 64'd4);
    i_data = 32'd5; i_drive = 1'b1; q.push_back(32'd5);
    fc = 0;
    repeat (10) begin cyc(); if (o_free) fc++; end
    chk("full_no_free", 64'(fc), 64'd0);
    chk("full_count_holds", 64'(o_count), 64'd4);
    chk("full_head_is_1", 64'(o_data), 64'd1);
    i_ready = 1'b1;
    cyc();
    i_ready = 1'b0;
    chk("pop_push_count_4", 64'(o_count), 64'd4);
    chk("pop_push_free", 64'(o_free), 64'd1);
    n = 0;
    while (o_free && n < 20) begin cyc(); n++; end
    i_drive = 1'b0;
    repeat (SS + 3) cyc();
`ifdef MERGE_SYNC_BRIDGE_STAT_EN
    chk("stat_stall_cnt", 64'(o_stall_cnt - s0), 64'(10 - SS - 1));
    chk("stat_word_cnt", 64'(o_word_cnt - w0), 64'd5);
`else
    chk("stat_baseline_zero", 64'(w0 | s0), 64'd0);
`endif
    drain();
    toggle_rdy = 1'b1; i_ready = 1'b1;
    for (int i = 0; i < 10; i++) xfer($urandom, 0);
    toggle_rdy = 1'b0;
    drain();
    xfer($urandom, 20);
    chk("held_one_word", 64'(o_count), 64'(q.size()));
    chk("held_count_1", 64'(o_count), 64'd1);
    xfer($urandom, 0);
    chk("held_next_accepted", 64'(o_count), 64'd2);
    drain();
    xfer($urandom, 0);
    xfer($urandom, 0);
    i_data = $urandom; i_drive = 1'b1; q.push_back(i_data);
    n = 0;
    while (!o_free && n < 20) begin cyc(); n++; end
    chk("midrst_free_seen", 64'(o_free), 64'd1);
    chk("midrst_three_queued", 64'(o_count), 64'd3);
    rst = 1'b1;
    cyc();
    chk("midrst_free", 64'(o_free), 64'd0);
    chk("midrst_count", 64'(o_count), 64'd0);
    chk("midrst_valid", 64'(o_valid), 64'd0);
    chk("midrst_data", 64'(o_data), 64'd0);
    q.delete();
    i_drive = 1'b0;
    cyc();
    rst = 1'b0;
    repeat (SS + 3) cyc();
    xfer($urandom, 0);
    chk("post_rst_count", 64'(o_count), 64'd1);
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/merge_sync_bridge.md
Name: merge_sync_bridge

Overview:
- Downstream sink for the 5-way mutex-merge stage. Converts its asynchronous drive/free bundled-data channel into a clocked valid/ready stream.
- Synchronizes the incoming drive request and captures the merged data word into a small FIFO.
- Returns a free pulse to the merge stage, then presents the words to synchronous logic.
- Sits at the async-to-sync boundary ahead of the clocked matrix datapath.

Parameters:
- DATA_WIDTH, 32: width of the merged data word.
- FIFO_DEPTH, 4: FIFO entries; power of two, ≥2.
- SYNC_STAGES, 2: flip-flop stages on i_drive; ≥2.
- FREE_PULSE_CYCLES, 2: o_free high time, in clk cycles; ≥1.

Ports:
- clk  input  1  single clock for the whole block.
- rst  input  1  synchronous, active-high reset.
- i_drive  input  1  async request from the merge stage; rising edge = new word.
- i_data  input  DATA_WIDTH  merged data; bundled and stable from before i_drive rises until o_free is issued.
- o_free  output  1  acknowledge pulse back to the merge stage (feeds its i_freeNext).
- o_valid  output  1  output word available.
- i_ready  input  1  consumer accepts the word when o_valid & i_ready at a clk edge.
- o_data  output  DATA_WIDTH  FIFO head word.
- o_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst=1 at a clk edge): all state cleared.
  - o_free=0, o_valid=0, o_data=0, o_count=0.
  - Synchronizer flops = 0; FSM = IDLE.
- Sync path:
  - i_drive passes through SYNC_STAGES flops to give drv_s.
  - drv_s is registered once more to give drv_d.
  - rise = drv_s & ~drv_d.
- Input FSM:
  - IDLE: on rise → CAPTURE.
  - CAPTURE:
    - FIFO not full, or a pop happens this same cycle: write i_data into the FIFO, load the pulse counter with FREE_PULSE_CYCLES, → FREE.
    - Otherwise stay in CAPTURE; no data is lost and the merge stage stays stalled.
  - FREE:
    - o_free=1 (registered) while counter>0; counter decrements each cycle.
    - At 0, o_free drops → WAIT_LOW.
  - WAIT_LOW: stay until drv_s==0, then → IDLE. This prevents a held-high drive from being counted twice.
  - A rise seen outside IDLE is ignored. The merge protocol forbids a new drive before free.
- Latency:
  - Drive rising edge → word written: SYNC_STAGES+1 cycles (+ synchronizer uncertainty of ≤1 cycle).
  - Write → o_valid=1: 1 cycle (registered head).
  - Write → o_free high: 1 cycle.
- FIFO:
  - Circular buffer with wrap-around read/write pointers.
  - Push and pop in the same cycle: occupancy unchanged.
  - Push and pop in the same cycle when full: allowed.
  - Pop when empty: cannot occur, since o_valid=0.
- Output:
  - o_valid = (count != 0).
  - o_data = head entry; holds while o_valid & ~i_ready.
  - o_data = 0 when empty.
- Reset mid-operation:
  - Applied during FREE: o_free drops the next cycle.
  - The FIFO contents are discarded.
  - Upstream is responsible for its own reset, which is applied together with this one.
- Width rules:
  - o_count saturates naturally at FIFO_DEPTH; it never exceeds FIFO_DEPTH.
  - Pointers are $clog2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro: MERGE_SYNC_BRIDGE_STAT_EN.
- Defined:
  - Adds output o_stall_cnt [15:0], a counter of cycles spent in CAPTURE with the FIFO full and no pop.
  - The counter saturates at 16'hFFFF and is cleared by rst.
  - Adds output o_word_cnt [15:0], a count of accepted words, which wraps at 16'hFFFF→0.
- Not defined: neither port exists and no counter logic is synthesized. Core behaviour is identical in both builds.

Test Plan:
- Reset with defaults: rst=1 for 3 cycles → o_free=0, o_valid=0, o_count=0, o_data=0.
- Single transfer:
  - Stimulus: i_data=32'hA5A5_0001, i_drive raised; i_ready=1.
  - Response: o_valid=1 exactly SYNC_STAGES+2 (±1) cycles after the edge, with o_data=32'hA5A5_0001.
  - Response: o_free high for exactly 2 cycles.
  - Response: o_count returns to 0 after the pop.
- Fill and backpressure:
  - Stimulus: i_ready=0; 5 transfers with data 1..5, each drive dropped after o_free.
  - Response: first 4 transfers freed, o_count=4.
  - Response: 5th transfer holds in CAPTURE with no o_free.
  - Stimulus: raise i_ready for 1 cycle.
  - Response: pops 1, word 5 is written in the same cycle, o_free issued, o_count stays 4.
  - Response: output order is 1,2,3,4,5.
- Wrap-around: 10 back-to-back transfers with i_ready toggling 1/0 each cycle → all 10 values emerge in order, no loss or duplicates.
- Held drive:
  - Stimulus: i_drive held high for 20 cycles after o_free.
  - Response: exactly one word written; the next transfer is accepted only after drive goes low then high.
- Reset mid-operation:
  - Stimulus: rst asserted during o_free high, with 3 words queued.
  - Response: next cycle o_free=0, o_count=0, o_valid=0.
- STAT_EN build: scenario 3 → o_stall_cnt equals the full-FIFO CAPTURE cycle count, and o_word_cnt=5.
